dcim_rwlb_driver: RTL and testbench

Bit-serial activation sequencer that drives the read-word-line-bar inputs (`rwlb_row0`, `rwlb_row1`, `sus`) of `local_mac`. It is the producer end of the local MAC input interface. It accepts a parallel vector of 8 multi-bit activations per row group. It then emits one bit-plane per cycle, LSB first, with per-plane framing, so that the downstream shift-accumulator can weight each `mac_out` result and negate the MSB plane in signed mode. It holds two vector slots (active plus pending), so back-to-back vectors stream with no bubble.

---
 rtl/dcim_pkg.sv | 28 ++
 rtl/dcim_bitplane_sel.sv | 26 ++
 rtl/dcim_rwlb_driver.sv | 138 +++++++++++++
 tb/tb_dcim_rwlb_driver.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcim_pkg.sv
// Shared definitions for the DCIM word-line driver: default geometry,
// plane-index width helper, the activation slot record and FSM states.
package dcim_pkg;

  localparam int DCIM_ACT_W = 8;
  localparam int DCIM_N_CH  = 8;

  // Width of a plane index: clog2 of the precision, never below 1 bit.
  function automatic int plane_idx_w(input int act_w);
    return (act_w > 1) ? $clog2(act_w) : 1;
  endfunction

  localparam int DCIM_PREC_W = plane_idx_w(DCIM_ACT_W) + 1;

  // One buffered activation vector; prec is already clamped to 1..ACT_W.
  typedef struct packed {
    logic [DCIM_N_CH*DCIM_ACT_W-1:0] act0;
    logic [DCIM_N_CH*DCIM_ACT_W-1:0] act1;
    logic                            sus;
    logic [DCIM_PREC_W-1:0]          prec;
  } dcim_slot_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } dcim_state_t;

endpackage

// File: rtl/dcim_bitplane_sel.sv
// Picks bit plane_idx out of every packed channel, one output bit per channel.
module dcim_bitplane_sel
  import dcim_pkg::*;
#(
  parameter int ACT_W = DCIM_ACT_W,
  parameter int N_CH  = DCIM_N_CH,
  parameter int IW    = plane_idx_w(DCIM_ACT_W)
) (
  input  logic [N_CH*ACT_W-1:0] act_flat,
  input  logic [IW-1:0]         plane_idx,
  output logic [N_CH-1:0]       plane_bits
);

  logic [ACT_W-1:0] ch;

  // Slice each channel, then index the requested bit position.
  always_comb begin
    plane_bits = '0;
    ch         = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch            = act_flat[i*ACT_W +: ACT_W];
      plane_bits[i] = ch[plane_idx];
    end
  end

endmodule

// File: rtl/dcim_rwlb_driver.sv
// Bit-serial activation sequencer feeding local_mac word lines: two vector
// slots (active + pending), LSB-first planes with first/last framing.
module dcim_rwlb_driver
  import dcim_pkg::*;
#(
  parameter  int ACT_W = DCIM_ACT_W,
  parameter  int N_CH  = DCIM_N_CH,
  localparam int IW    = plane_idx_w(ACT_W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_CH*ACT_W-1:0] in_act0,
  input  logic [N_CH*ACT_W-1:0] in_act1,
  input  logic                  in_sus,
  input  logic [IW:0]           in_prec,
  output logic [N_CH-1:0]       rwlb_row0,
  output logic [N_CH-1:0]       rwlb_row1,
  output logic                  sus,
  output logic                  plane_valid,
  input  logic                  plane_ready,
  output logic [IW-1:0]         plane_idx,
  output logic                  plane_first,
  output logic                  plane_last,
  output logic                  busy
);

  dcim_state_t     state;
  logic            pend_full;
  logic [IW-1:0]   idx;
  dcim_slot_t      act_slot;
  dcim_slot_t      pend_slot;
  dcim_slot_t      in_slot;
  logic            plane_on;
  logic            accept;
  logic            fire;
  logic            last_plane;
  logic            load_act_in;
  logic            load_act_pend;
  logic            load_pend;
  logic [N_CH-1:0] sel0;
  logic [N_CH-1:0] sel1;

  // Out-of-range precision (0 or above ACT_W) means full precision.
  function automatic logic [IW:0] clamp_prec(input logic [IW:0] p);
    if (p == '0 || p > (IW+1)'(ACT_W)) return (IW+1)'(ACT_W);
    return p;
  endfunction

  assign in_slot.act0 = in_act0;
  assign in_slot.act1 = in_act1;
  assign in_slot.sus  = in_sus;
  assign in_slot.prec = clamp_prec(in_prec);

  assign plane_on   = (state == ST_STREAM);
  assign accept     = in_valid & ~pend_full;
  assign fire       = plane_on & plane_ready;
  assign last_plane = ({1'b0, idx} == act_slot.prec - 1'b1);

  // Decide where an accepted vector lands and whether pending promotes.
  always_comb begin
    load_act_in   = 1'b0;
    load_act_pend = 1'b0;
    load_pend     = 1'b0;
    if (!plane_on) begin
      load_act_in = accept;
    end else if (fire && last_plane) begin
      if (pend_full) begin
        load_act_pend = 1'b1;
        load_pend     = accept;
      end else begin
        load_act_in = accept;
      end
    end else begin
      load_pend = accept;
    end
  end

  // Control state: FSM, plane counter and pending occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pend_full <= 1'b0;
      idx       <= '0;
    end else begin
      if (load_act_in || load_act_pend) begin
        state <= ST_STREAM;
        idx   <= '0;
      end else if (fire && last_plane) begin
        state <= ST_IDLE;
        idx   <= '0;
      end else if (fire) begin
        idx <= idx + 1'b1;
      end
      if (load_pend) begin
        pend_full <= 1'b1;
      end else if (load_act_pend) begin
        pend_full <= 1'b0;
      end
    end
  end

  // Slot payloads; contents are only observed while the FSM streams.
  always_ff @(posedge clk) begin
    if (load_act_in) begin
      act_slot <= in_slot;
    end else if (load_act_pend) begin
      act_slot <= pend_slot;
    end
    if (load_pend) begin
      pend_slot <= in_slot;
    end
  end

  dcim_bitplane_sel #(.ACT_W(ACT_W), .N_CH(N_CH), .IW(IW)) u_sel_row0 (
    .act_flat   (act_slot.act0),
    .plane_idx  (idx),
    .plane_bits (sel0)
  );

  dcim_bitplane_sel #(.ACT_W(ACT_W), .N_CH(N_CH), .IW(IW)) u_sel_row1 (
    .act_flat   (act_slot.act1),
    .plane_idx  (idx),
    .plane_bits (sel1)
  );

  assign rwlb_row0   = plane_on ? sel0 : '0;
  assign rwlb_row1   = plane_on ? sel1 : '0;
  assign sus         = plane_on & act_slot.sus;
  assign plane_valid = plane_on;
  assign plane_idx   = plane_on ? idx : '0;
  assign plane_first = plane_on & (idx == '0);
  assign plane_last  = plane_on & last_plane;
  assign in_ready    = ~pend_full;
  assign busy        = plane_on | pend_full;

endmodule

// File: tb/tb_dcim_rwlb_driver.sv
// Bench for dcim_rwlb_driver: table of single-vector cases, hand-written
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_dcim_rwlb_driver;

  localparam int ACT_W = 8;
  localparam int N_CH  = 8;
  localparam int IW    = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [N_CH*ACT_W-1:0] in_act0;
  logic [N_CH*ACT_W-1:0] in_act1;
  logic                  in_sus;
  logic [IW:0]           in_prec;
  logic [N_CH-1:0]       rwlb_row0;
  logic [N_CH-1:0]       rwlb_row1;
  logic                  sus;
  logic                  plane_valid;
  logic                  plane_ready;
  logic [IW-1:0]         plane_idx;
  logic                  plane_first;
  logic                  plane_last;
  logic                  busy;

  always #5 clk = ~clk;

  dcim_rwlb_driver #(.ACT_W(ACT_W), .N_CH(N_CH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_act0     (in_act0),
    .in_act1     (in_act1),
    .in_sus      (in_sus),
    .in_prec     (in_prec),
    .rwlb_row0   (rwlb_row0),
    .rwlb_row1   (rwlb_row1),
    .sus         (sus),
    .plane_valid (plane_valid),
    .plane_ready (plane_ready),
    .plane_idx   (plane_idx),
    .plane_first (plane_first),
    .plane_last  (plane_last),
    .busy        (busy)
  );

  // Reference model: queue of accepted vectors, head is streaming.
  typedef struct {
    logic [63:0] act0;
    logic [63:0] act1;
    logic        sus;
    int          prec;
  } vec_t;

  typedef struct {
    logic [63:0] act0;
    logic [63:0] act1;
    logic        sus;
    logic [3:0]  prec;
    int          exp_planes;
    logic [7:0]  exp_r0_last;
    logic [7:0]  exp_r1_last;
  } tvec_t;

  vec_t  q[$];
  int    cur_plane = 0;
  int    total = 0;
  int    bad = 0;
  bit    last_acc;
  int    cyc = 0;
  int    vcount, vfirst, vlast;
  tvec_t tbl[6];

  function automatic int eff_prec(input int p);
    return (p == 0 || p > ACT_W) ? ACT_W : p;
  endfunction

  // Bit p of every channel value, computed arithmetically per channel.
  function automatic logic [7:0] plane_bits(input logic [63:0] a, input int p);
    logic [7:0] r;
    int chv;
    r = '0;
    for (int i = 0; i < N_CH; i++) begin
      chv  = int'((a >> (i * ACT_W)) & 64'hFF);
      r[i] = ((chv / (1 << p)) % 2) == 1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] e0, e1;
    logic es, ef, el, ev;
    int ei;
    e0 = '0; e1 = '0; es = 0; ef = 0; el = 0; ei = 0;
    ev = (q.size() > 0);
    if (ev) begin
      e0 = plane_bits(q[0].act0, cur_plane);
      e1 = plane_bits(q[0].act1, cur_plane);
      es = q[0].sus;
      ei = cur_plane;
      ef = (cur_plane == 0);
      el = (cur_plane == q[0].prec - 1);
    end
    chk("plane_valid", plane_valid, ev);
    chk("in_ready", in_ready, q.size() < 2);
    chk("busy", busy, ev);
    chk("rwlb_row0", rwlb_row0, e0);
    chk("rwlb_row1", rwlb_row1, e1);
    chk("sus", sus, es);
    chk("plane_idx", plane_idx, ei);
    chk("plane_first", plane_first, ef);
    chk("plane_last", plane_last, el);
    if (plane_valid === 1'b1) begin
      if (vcount == 0) vfirst = cyc;
      vlast = cyc;
      vcount++;
    end
  endtask

  // Check at the falling edge, advance one clock, update the model.
  task automatic step();
    bit acc, fire;
    vec_t v;
    check_outputs();
    acc  = in_valid && (q.size() < 2) && rst_n;
    fire = (q.size() > 0) && plane_ready;
    v.act0 = in_act0; v.act1 = in_act1; v.sus = in_sus;
    v.prec = eff_prec(int'(in_prec));
    last_acc = acc;
    @(posedge clk);
    if (fire) begin
      cur_plane++;
      if (cur_plane == q[0].prec) begin
        void'(q.pop_front());
        cur_plane = 0;
      end
    end
    if (acc) q.push_back(v);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input logic [63:0] a0, input logic [63:0] a1,
                       input logic s, input logic [3:0] p);
    in_valid = 1'b1; in_act0 = a0; in_act1 = a1; in_sus = s; in_prec = p;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    plane_ready = 1'b1;
    for (int c = 0; c < 40 && q.size() > 0; c++) step();
    chk("drain_done", q.size(), 0);
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] r0, r1;
    bit saw_block;

    tbl[0] = '{64'hA5, 64'h0, 1'b0, 4'd8, 8, 8'h01, 8'h00};
    tbl[1] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd4, 4, 8'h00, 8'hFF};
    tbl[2] = '{64'h8080_8080_8080_8080, 64'h0, 1'b0, 4'd0, 8, 8'hFF, 8'h00};
    tbl[3] = '{64'h0, 64'h0000_0000_8000_0000, 1'b0, 4'd15, 8, 8'h00, 8'h08};
    tbl[4] = '{64'h0100_0000_0000_0000, 64'h0, 1'b0, 4'd1, 1, 8'h80, 8'h00};
    tbl[5] = '{64'h0000_0000_0000_0400, 64'h08, 1'b1, 4'd3, 3, 8'h02, 8'h00};

    rst_n = 1'b0; in_valid = 1'b0; in_act0 = '0; in_act1 = '0;
    in_sus = 1'b0; in_prec = '0; plane_ready = 1'b0;
    vcount = 0; vfirst = 0; vlast = 0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    step();

    // Table-driven single vectors.
    for (int t = 0; t < 6; t++) begin
      plane_ready = 1'b1;
      drive(tbl[t].act0, tbl[t].act1, tbl[t].sus, tbl[t].prec);
      step();
      in_valid = 1'b0;
      n = 0; r0 = '0; r1 = '0;
      for (int c = 0; c < 20 && q.size() > 0; c++) begin
        if (plane_valid) begin
          n++;
          if (plane_last) begin r0 = rwlb_row0; r1 = rwlb_row1; end
        end
        step();
      end
      chk($sformatf("tbl%0d_planes", t), n, tbl[t].exp_planes);
      chk($sformatf("tbl%0d_row0_last", t), r0, tbl[t].exp_r0_last);
      chk($sformatf("tbl%0d_row1_last", t), r1, tbl[t].exp_r1_last);
      step();
    end

    // Three back-to-back vectors stream without a bubble.
    plane_ready = 1'b1;
    vcount = 0; saw_block = 0;
    drive({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 4'd8);
    step();
    drive({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 4'd8);
    step();
    drive({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 4'd8);
    last_acc = 0;
    for (int c = 0; c < 20 && !last_acc; c++) begin
      if (in_ready === 1'b0) saw_block = 1;
      step();
    end
    chk("b2b_accepted", last_acc, 1);
    chk("b2b_inready_drop", saw_block, 1);
    drain();
    chk("b2b_planes", vcount, 24);
    chk("b2b_contiguous", vlast - vfirst + 1, 24);

    // Stall at plane 2 for three cycles, then resume.
    drive({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 4'd8);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 10 && cur_plane != 2; c++) step();
    plane_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("stall_idx", plane_idx, 2);
      step();
    end
    plane_ready = 1'b1;
    step();
    chk("resume_idx", plane_idx, 3);
    drain();

    // Reset mid-stream with pending occupied.
    drive({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 4'd8);
    step();
    drive({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 4'd8);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 10 && cur_plane != 4; c++) step();
    chk("rst_pre_idx", plane_idx, 4);
    chk("rst_pre_inready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", plane_valid, 0);
    chk("rst_row0", rwlb_row0, 0);
    chk("rst_row1", rwlb_row1, 0);
    chk("rst_sus", sus, 0);
    chk("rst_idx", plane_idx, 0);
    chk("rst_first", plane_first, 0);
    chk("rst_last", plane_last, 0);
    chk("rst_inready", in_ready, 1);
    chk("rst_busy", busy, 0);
    q.delete();
    cur_plane = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) step();

    // Randomized traffic and backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_act0     = {$urandom, $urandom};
      in_act1     = {$urandom, $urandom};
      in_sus      = 1'($urandom_range(0, 1));
      in_prec     = 4'($urandom_range(0, 15));
      plane_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
